// File: rtl/cb_handshake_ep.sv
// Valid/ready receive endpoint: registered ready echo feeding a one-entry holding register.
// Optional accepted-beat counter enabled by defining CB_HANDSHAKE_EP_XFER_CNT_EN.
module cb_handshake_ep #(
  parameter int D_WIDTH   = 1,
  parameter int A_WIDTH   = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [D_WIDTH-1:0] data,
  input  logic [A_WIDTH-1:0] addr,
  output logic               ready,
  input  logic               grant,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data,
  output logic [A_WIDTH-1:0] out_addr,
  output logic               overflow
`ifdef CB_HANDSHAKE_EP_XFER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] xfer_cnt
`endif
);

  if (D_WIDTH < 1 || A_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("cb_handshake_ep: all widths must be at least 1");
  end

  logic               ready_q;
  logic               out_valid_q, out_valid_d;
  logic [D_WIDTH-1:0] out_data_q, out_data_d;
  logic [A_WIDTH-1:0] out_addr_q, out_addr_d;
  logic               overflow_q, overflow_d;
  logic               accept;

  assign accept = valid && ready_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    overflow_d  = overflow_q;
    if (accept) begin
      if (!out_valid_q || grant) begin
        out_valid_d = 1'b1;
        out_data_d  = data;
        out_addr_d  = addr;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (grant) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  // NOTE: the payload registers are reset too, because out_data/out_addr must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ready_q     <= valid;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef CB_HANDSHAKE_EP_XFER_CNT_EN
  // Counts every accepted beat, dropped ones included; wraps silently.
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif

  assign ready     = ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cb_handshake_ep.sv
// Directed bench for cb_handshake_ep: constant checks plus a beat scoreboard queue.
// Counter checks are compiled in when CB_HANDSHAKE_EP_XFER_CNT_EN is defined.
module tb_cb_handshake_ep;
  localparam int DW = 1;
  localparam int AW = 1;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          ready;
  logic          grant;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          overflow;
`ifdef CB_HANDSHAKE_EP_XFER_CNT_EN
  logic [CW-1:0] xfer_cnt;
`endif

  int    n_total  = 0;
  int    n_passed = 0;
  int    exp_cnt  = 0;
  beat_t sb_q[$];

  cb_handshake_ep #(.D_WIDTH(DW), .A_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .data     (data),
    .addr     (addr),
    .ready    (ready),
    .grant    (grant),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_addr (out_addr),
    .overflow (overflow)
`ifdef CB_HANDSHAKE_EP_XFER_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit held);
    beat_t b;
    data = d;
    addr = a;
    if (held) begin
      b.d = d;
      b.a = a;
      sb_q.push_back(b);
    end
  endtask

  // Compare the newly held beat against the oldest expected one.
  task automatic sb_check(input string tag);
    beat_t b;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      b = sb_q.pop_front();
      check({tag, "_data"}, 32'(out_data), 32'(b.d));
      check({tag, "_addr"}, 32'(out_addr), 32'(b.a));
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef CB_HANDSHAKE_EP_XFER_CNT_EN
    check(tag, 32'(xfer_cnt), 32'(exp_cnt % (1 << CW)));
`else
    if (tag.len() == 0) $error("FAIL check_cnt: empty tag");
`endif
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    addr  = '0;
    grant = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready",     32'(ready),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_addr",  32'(out_addr),  32'd0);
    check_cnt("rst_cnt");

    // Ready echo and single beat.
    valid = 1'b1;
    drive_beat(1'b1, 1'b1, 1'b0);
    step();
    check("echo_ready_up",   32'(ready),     32'd1);
    check("echo_no_accept",  32'(out_valid), 32'd0);
    drive_beat(1'b1, 1'b1, 1'b1);
    step();
    exp_cnt++;
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_overflow",  32'(overflow),  32'd0);
    sb_check("single");
    check_cnt("single_cnt");
    valid = 1'b0;
    data  = 'x;
    addr  = 'x;
    step();
    check("echo_ready_down", 32'(ready),     32'd0);
    check("single_hold",     32'(out_valid), 32'd1);
    check("single_x_ignored", 32'(out_data), 32'd1);
    grant = 1'b1;
    step();
    check("grant_clear",     32'(out_valid), 32'd0);
    check("grant_keep_data", 32'(out_data),  32'd1);
    step();
    check("grant_idle",      32'(out_valid), 32'd0);
    grant = 1'b0;

    // Overflow: hold first accepted beat, drop the second.
    valid = 1'b1;
    data  = 'x;
    addr  = 'x;
    step();
    check("ovf_ready", 32'(ready), 32'd1);
    drive_beat(1'b1, 1'b0, 1'b1);
    step();
    exp_cnt++;
    sb_check("ovf_first");
    check("ovf_not_yet", 32'(overflow), 32'd0);
    drive_beat(1'b0, 1'b1, 1'b0);
    step();
    exp_cnt++;
    check("ovf_sticky",     32'(overflow),  32'd1);
    check("ovf_keep_data",  32'(out_data),  32'd1);
    check("ovf_keep_addr",  32'(out_addr),  32'd0);
    check("ovf_keep_valid", 32'(out_valid), 32'd1);
    check_cnt("ovf_cnt");

    // Release plus reload on the same edge.
    grant = 1'b1;
    drive_beat(1'b0, 1'b0, 1'b1);
    step();
    exp_cnt++;
    check("reload_valid",    32'(out_valid), 32'd1);
    check("reload_overflow", 32'(overflow),  32'd1);
    sb_check("reload");
    valid = 1'b0;
    data  = 'x;
    addr  = 'x;
    step();
    check("reload_release", 32'(out_valid), 32'd0);
    check("reload_ready",   32'(ready),     32'd0);

    // Streaming with grant held: every beat reloads; counter wraps.
    valid = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      drive_beat(DW'(k & 1), AW'(~k & 1), 1'b1);
      step();
      exp_cnt++;
      check("stream_valid", 32'(out_valid), 32'd1);
      sb_check("stream");
      check_cnt("stream_cnt");
    end
    check("stream_overflow_kept", 32'(overflow), 32'd1);

    // Asynchronous reset mid-cycle with a beat held and valid high.
    grant = 1'b0;
    drive_beat(1'b1, 1'b1, 1'b0);
    step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ready",     32'(ready),     32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_overflow",  32'(overflow),  32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_out_addr",  32'(out_addr),  32'd0);
    exp_cnt = 0;
    check_cnt("arst_cnt");
    step();
    check("arst_priority", 32'(ready), 32'd0);
    rst = 1'b0;
    valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
